// File: rtl/alu_pkg.sv
// alu_pkg: shared opcodes, FSM states and helpers
// for the sequential EX-stage ALU.
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_MULTU = 4'b1000;
  localparam logic [3:0] OP_DIVU  = 4'b1001;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  // Two's complement overflow from operand/result sign bits.
  function automatic logic ovf_f(
    input logic sa,
    input logic sb,
    input logic sr,
    input logic sub
  );
    if (sub) return (sa != sb) && (sr != sa);
    return (sa == sb) && (sr != sa);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: one-bit-per-cycle unsigned
// multiply (shift-add) and divide (restoring).
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             is_div,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             cnt_zero,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH-1:0]   opnd_q;
  logic [CW-1:0]      cnt_q;
  logic               div_q;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     tmp;
  logic [WIDTH:0]     dif;
  logic               ge;
  logic [WIDTH-1:0]   rem;

  // Next accumulator: the step the final cycle also registers upstream.
  always_comb begin
    acc_d = acc_q;
    sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
          + (acc_q[0] ? {1'b0, opnd_q} : '0);
    tmp   = acc_q[2*WIDTH-1:WIDTH-1];
    dif   = tmp - {1'b0, opnd_q};
    ge    = ~dif[WIDTH];
    rem   = ge ? dif[WIDTH-1:0] : tmp[WIDTH-1:0];
    if (div_q)
      acc_d = {rem, acc_q[WIDTH-2:0], ge};
    else
      acc_d = {sum, acc_q[WIDTH-1:1]};
  end

  assign res_lo   = acc_d[WIDTH-1:0];
  assign res_hi   = acc_d[2*WIDTH-1:WIDTH];
  assign cnt_zero = (cnt_q == '0);

  // Operand capture on load, one iteration per step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q  <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
      div_q  <= 1'b0;
    end else if (load) begin
      acc_q  <= {{WIDTH{1'b0}}, a};
      opnd_q <= b;
      cnt_q  <= CW'(WIDTH - 1);
      div_q  <= is_div;
    end else if (step) begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: EX-stage ALU with single-cycle logic/arith
// and iterative MULTU/DIVU behind start/busy/done.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       ALUOp,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             overflow,
  output logic             div_zero
);

  state_e           state_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] hi_q;
  logic             zero_q;
  logic             ovf_q;
  logic             dz_q;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] dif;
  logic [WIDTH-1:0] sc_lo;
  logic             sc_ovf;
  logic             is_mul;
  logic             is_div;
  logic             b_zero;
  logic             load;
  logic             step;
  logic             cnt_zero;
  logic [WIDTH-1:0] it_lo;
  logic [WIDTH-1:0] it_hi;

  // Single-cycle result and iterative-unit control.
  always_comb begin
    sum    = a + b;
    dif    = a - b;
    sc_lo  = '0;
    sc_ovf = 1'b0;
    case (ALUOp)
      OP_AND: sc_lo = a & b;
      OP_OR:  sc_lo = a | b;
      OP_NOR: sc_lo = ~(a | b);
      OP_ADD: begin
        sc_lo  = sum;
        sc_ovf = ovf_f(a[WIDTH-1], b[WIDTH-1],
                       sum[WIDTH-1], 1'b0);
      end
      OP_SUB: begin
        sc_lo  = dif;
        sc_ovf = ovf_f(a[WIDTH-1], b[WIDTH-1],
                       dif[WIDTH-1], 1'b1);
      end
      OP_SLT: sc_lo = {{(WIDTH-1){1'b0}},
                       $signed(a) < $signed(b)};
      default: begin
        sc_lo  = '0;
        sc_ovf = 1'b0;
      end
    endcase
    is_mul = (ALUOp == OP_MULTU);
    is_div = (ALUOp == OP_DIVU);
    b_zero = (b == '0);
    load   = (state_q == IDLE) && start
           && (is_mul || (is_div && !b_zero));
    step   = (state_q == RUN);
  end

  alu_muldiv_iter #(
    .WIDTH(WIDTH)
  ) u_iter (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .is_div  (is_div),
    .step    (step),
    .a       (a),
    .b       (b),
    .cnt_zero(cnt_zero),
    .res_lo  (it_lo),
    .res_hi  (it_hi)
  );

  // Control FSM; results and flags change only with done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      zero_q  <= 1'b1;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (load) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
          end else if (start) begin
            done_q <= 1'b1;
            if (is_div) begin
              lo_q   <= '1;
              hi_q   <= a;
              zero_q <= 1'b0;
              ovf_q  <= 1'b0;
              dz_q   <= 1'b1;
            end else begin
              lo_q   <= sc_lo;
              hi_q   <= '0;
              zero_q <= (sc_lo == '0);
              ovf_q  <= sc_ovf;
              dz_q   <= 1'b0;
            end
          end
        end
        RUN: begin
          if (cnt_zero) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            lo_q    <= it_lo;
            hi_q    <= it_hi;
            zero_q  <= (it_lo == '0);
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign lo       = lo_q;
  assign hi       = hi_q;
  assign zero     = zero_q;
  assign overflow = ovf_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: table vectors plus corner sequences,
// expected results queued at issue, compared at done.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 32;
  localparam int NV = 15;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         z;
    logic         ov;
    logic         dz;
    int           lat;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   ALUOp = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] lo;
  logic [W-1:0] hi;
  logic         zero;
  logic         overflow;
  logic         div_zero;

  int checks = 0;
  int errors = 0;

  vec_t tv [NV];
  vec_t sb_q [$];

  alu_seq #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .ALUOp   (ALUOp),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .lo      (lo),
    .hi      (hi),
    .zero    (zero),
    .overflow(overflow),
    .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h",
               n, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [3:0] op, input logic [W-1:0] ia,
    input logic [W-1:0] ib, input logic [W-1:0] elo,
    input logic [W-1:0] ehi, input logic ez,
    input logic eov, input logic edz, input int el);
    vec_t v;
    v.op = op; v.a = ia; v.b = ib;
    v.lo = elo; v.hi = ehi; v.z = ez;
    v.ov = eov; v.dz = edz; v.lat = el;
    return v;
  endfunction

  task automatic issue(input vec_t v);
    @(negedge clk);
    start = 1'b1;
    ALUOp = v.op;
    a = v.a;
    b = v.b;
    sb_q.push_back(v);
  endtask

  // Edge 0 is the next rising edge; poke_k injects a
  // one-cycle AND start while the unit is busy.
  task automatic wait_done(input string n,
                           input int poke_k);
    int k;
    int nbusy;
    vec_t e;
    k = 0;
    nbusy = 0;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    ALUOp = 4'($urandom);
    while (!done && k < 100) begin
      if (busy) nbusy++;
      @(negedge clk);
      if (k == poke_k) begin
        start = 1'b1;
        ALUOp = OP_AND;
        a = '1;
        b = '1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      k++;
    end
    if (!done) begin
      errors++;
      checks++;
      $display("FAIL %s timeout actual=%0d required<100",
               n, k);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
    end else if (sb_q.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL %s unexpected done actual=1 required=0",
               n);
    end else begin
      e = sb_q.pop_front();
      chk({n, ".lat"}, 64'(k), 64'(e.lat));
      chk({n, ".busycyc"}, 64'(nbusy), 64'(e.lat));
      chk({n, ".busy@done"}, 64'(busy), 64'd0);
      chk({n, ".lo"}, 64'(lo), 64'(e.lo));
      chk({n, ".hi"}, 64'(hi), 64'(e.hi));
      chk({n, ".zero"}, 64'(zero), 64'(e.z));
      chk({n, ".ovf"}, 64'(overflow), 64'(e.ov));
      chk({n, ".dz"}, 64'(div_zero), 64'(e.dz));
    end
  endtask

  task automatic chk_reset_vals(input string n);
    chk({n, ".busy"}, 64'(busy), 64'd0);
    chk({n, ".done"}, 64'(done), 64'd0);
    chk({n, ".lo"}, 64'(lo), 64'd0);
    chk({n, ".hi"}, 64'(hi), 64'd0);
    chk({n, ".zero"}, 64'(zero), 64'd1);
    chk({n, ".ovf"}, 64'(overflow), 64'd0);
    chk({n, ".dz"}, 64'(div_zero), 64'd0);
  endtask

  initial begin
    logic [63:0] p;
    int ndone;
    p = 64'h12345678 * 64'h9ABCDEF0;

    tv[0]  = mk(OP_ADD, 32'h7FFFFFFF, 32'h1,
                32'h80000000, 0, 0, 1, 0, 0);
    tv[1]  = mk(OP_SUB, 32'd5, 32'd5, 0, 0, 1, 0, 0, 0);
    tv[2]  = mk(OP_AND, 32'hF0F0F0F0, 32'hFF00FF00,
                32'hF000F000, 0, 0, 0, 0, 0);
    tv[3]  = mk(OP_OR, 32'h0F0F0000, 32'h000000F0,
                32'h0F0F00F0, 0, 0, 0, 0, 0);
    tv[4]  = mk(OP_NOR, 32'h0, 32'h0,
                32'hFFFFFFFF, 0, 0, 0, 0, 0);
    tv[5]  = mk(OP_SUB, 32'h80000000, 32'h1,
                32'h7FFFFFFF, 0, 0, 1, 0, 0);
    tv[6]  = mk(OP_SLT, 32'h1, 32'hFFFFFFFF,
                0, 0, 1, 0, 0, 0);
    tv[7]  = mk(OP_SLT, 32'hFFFFFFFF, 32'h1,
                1, 0, 0, 0, 0, 0);
    tv[8]  = mk(4'b0011, 32'h1234, 32'h5678,
                0, 0, 1, 0, 0, 0);
    tv[9]  = mk(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
                32'h1, 32'hFFFFFFFE, 0, 0, 0, 32);
    tv[10] = mk(OP_DIVU, 32'd100, 32'd7,
                32'd14, 32'd2, 0, 0, 0, 32);
    tv[11] = mk(OP_DIVU, 32'd9, 32'd0,
                32'hFFFFFFFF, 32'd9, 0, 0, 1, 0);
    tv[12] = mk(OP_MULTU, 32'h12345678, 32'h9ABCDEF0,
                p[31:0], p[63:32], p[31:0] == 0,
                0, 0, 32);
    tv[13] = mk(OP_DIVU, 32'hFFFFFFFF, 32'd3,
                32'h55555555, 32'd0, 0, 0, 0, 32);
    tv[14] = mk(OP_DIVU, 32'd5, 32'd10,
                32'd0, 32'd5, 1, 0, 0, 32);

    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("por");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      issue(tv[i]);
      wait_done($sformatf("v%0d", i), -1);
      @(posedge clk); #1;
      chk($sformatf("v%0d.pulse", i), 64'(done), 64'd0);
    end

    // AND poke while busy must be ignored; then issue
    // a new op in the done cycle itself.
    issue(mk(OP_MULTU, 32'd3, 32'd4,
             32'd12, 32'd0, 0, 0, 0, 32));
    wait_done("poke", 10);
    start = 1'b1;
    ALUOp = OP_ADD;
    a = 32'd2;
    b = 32'd3;
    sb_q.push_back(mk(OP_ADD, 32'd2, 32'd3,
                      32'd5, 0, 0, 0, 0, 0));
    wait_done("b2b", -1);
    @(posedge clk); #1;
    chk("b2b.pulse", 64'(done), 64'd0);

    // Reset mid-DIVU, between clock edges.
    @(negedge clk);
    start = 1'b1;
    ALUOp = OP_DIVU;
    a = 32'd100;
    b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("mid.busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    chk_reset_vals("mid");
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("mid.nodone", 64'(ndone), 64'd0);
    chk("mid.busy_after", 64'(busy), 64'd0);

    issue(mk(OP_SLT, 32'hFFFFFFFF, 32'd1,
             32'd1, 0, 0, 0, 0, 0));
    wait_done("slt", -1);

    chk("sb.empty", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
